// File: rtl/mem_guard_pkg.sv
// Shared constants and types for the mem_guard data-memory access checker.
// Optional feature macro used across the slice: MEM_GUARD_LOCK_EN.
package mem_guard_pkg;

   localparam int PERM_RD = 0;
   localparam int PERM_WR = 1;
   localparam int PERM_EN = 2;
   localparam int PERM_W  = 3;

   localparam logic [31:0] LEGACY_BASE  = 32'd0;
   localparam logic [31:0] LEGACY_LIMIT = 32'd4;

   typedef enum logic {
      CLEAR    = 1'b0,
      CAPTURED = 1'b1
   } guard_state_t;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mem_guard_if.sv
// Access, configuration and violation-report signals of mem_guard.
// With MEM_GUARD_LOCK_EN defined the interface also carries the locked flag.
interface mem_guard_if #(
   parameter int ADDR_W = 32,
   parameter int IDX_W  = 2,
   parameter int CNT_W  = 8
);

   logic              memread;
   logic              memwrite;
   logic [ADDR_W-1:0] addr;
   logic              cfg_we;
   logic [IDX_W-1:0]  cfg_idx;
   logic [ADDR_W-1:0] cfg_base;
   logic [ADDR_W-1:0] cfg_limit;
   logic [2:0]        cfg_perm;
   logic              viol_clr;
   logic              rd;
   logic              w;
   logic              viol;
   logic              viol_sticky;
   logic [ADDR_W-1:0] viol_addr;
   logic [CNT_W-1:0]  viol_cnt;
   logic [IDX_W-1:0]  hit_idx;
`ifdef MEM_GUARD_LOCK_EN
   logic              locked;

   modport master (
      output memread, memwrite, addr, cfg_we, cfg_idx, cfg_base, cfg_limit,
             cfg_perm, viol_clr,
      input  rd, w, viol, viol_sticky, viol_addr, viol_cnt, hit_idx, locked
   );

   modport slave (
      input  memread, memwrite, addr, cfg_we, cfg_idx, cfg_base, cfg_limit,
             cfg_perm, viol_clr,
      output rd, w, viol, viol_sticky, viol_addr, viol_cnt, hit_idx, locked
   );
`else
   modport master (
      output memread, memwrite, addr, cfg_we, cfg_idx, cfg_base, cfg_limit,
             cfg_perm, viol_clr,
      input  rd, w, viol, viol_sticky, viol_addr, viol_cnt, hit_idx
   );

   modport slave (
      input  memread, memwrite, addr, cfg_we, cfg_idx, cfg_base, cfg_limit,
             cfg_perm, viol_clr,
      output rd, w, viol, viol_sticky, viol_addr, viol_cnt, hit_idx
   );
`endif

endinterface

// File: rtl/mem_guard_region.sv
// One programmable address region: registered bounds and permissions with a
// combinational inclusive-range hit and per-direction permission flags.
module mem_guard_region
   import mem_guard_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter bit IS_LEGACY = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_wr,
   input  logic [ADDR_W-1:0] cfg_base,
   input  logic [ADDR_W-1:0] cfg_limit,
   input  logic [2:0]        cfg_perm,
   input  logic [ADDR_W-1:0] addr,
   output logic              hit,
   output logic              rd_ok,
   output logic              wr_ok
);

   logic [ADDR_W-1:0] base_p1;
   logic [ADDR_W-1:0] limit_p1;
   logic [2:0]        perm_p1;

   // Region 0 comes out of reset as the legacy fixed window so that
   // unconfigured systems behave exactly as before.
   always_ff @(posedge clk) begin
      if (rst) begin
         base_p1  <= IS_LEGACY ? ADDR_W'(LEGACY_BASE)  : '0;
         limit_p1 <= IS_LEGACY ? ADDR_W'(LEGACY_LIMIT) : '0;
         perm_p1  <= IS_LEGACY ? 3'b111 : 3'b000;
      end else if (cfg_wr) begin
         base_p1  <= cfg_base;
         limit_p1 <= cfg_limit;
         perm_p1  <= cfg_perm;
      end
   end

   // An inverted range (base > limit) fails one of the two compares.
   assign hit   = perm_p1[PERM_EN] && (base_p1 <= addr) && (addr <= limit_p1);
   assign rd_ok = perm_p1[PERM_RD];
   assign wr_ok = perm_p1[PERM_WR];

endmodule

// File: rtl/mem_guard.sv
// Top of the data-memory access checker: NUM_REGIONS regions, lowest index
// wins, registered grants, first-violation capture. Optional: MEM_GUARD_LOCK_EN.
module mem_guard
   import mem_guard_pkg::*;
#(
   parameter int NUM_REGIONS = 4,
   parameter int ADDR_W      = 32,
   parameter int CNT_W       = 8
) (
   input logic        clk,
   input logic        rst,
   mem_guard_if.slave bus
);

   localparam int IDX_W = idx_width(NUM_REGIONS);

   logic [NUM_REGIONS-1:0] hit;
   logic [NUM_REGIONS-1:0] rd_ok;
   logic [NUM_REGIONS-1:0] wr_ok;
   logic                   cfg_ok;

   logic                   win_found;
   logic [IDX_W-1:0]       win_idx;
   logic                   win_rd;
   logic                   win_wr;

   logic                   dec_rd;
   logic                   dec_wr;
   logic                   dec_viol;
   logic [IDX_W-1:0]       dec_hit;

   logic                   rd_p1;
   logic                   wr_p1;
   logic                   viol_p1;
   logic [IDX_W-1:0]       hit_p1;
   logic [ADDR_W-1:0]      viol_addr_p1;
   logic [CNT_W-1:0]       viol_cnt_p1;

   guard_state_t           state_p1;
   guard_state_t           state_d;
   logic [ADDR_W-1:0]      viol_addr_d;
   logic [CNT_W-1:0]       viol_cnt_d;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
   endfunction

`ifdef MEM_GUARD_LOCK_EN
   logic locked_p1;

   assign cfg_ok = bus.cfg_we && !locked_p1;

   // Writing the top region with its enable bit set freezes the whole table.
   always_ff @(posedge clk) begin
      if (rst) begin
         locked_p1 <= 1'b0;
      end else if (cfg_ok && (bus.cfg_idx == IDX_W'(NUM_REGIONS - 1))
                   && bus.cfg_perm[PERM_EN]) begin
         locked_p1 <= 1'b1;
      end
   end

   assign bus.locked = locked_p1;
`else
   assign cfg_ok = bus.cfg_we;
`endif

   for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_region
      mem_guard_region #(
         .ADDR_W    (ADDR_W),
         .IS_LEGACY (g == 0)
      ) u_region (
         .clk       (clk),
         .rst       (rst),
         .cfg_wr    (cfg_ok && (bus.cfg_idx == IDX_W'(g))),
         .cfg_base  (bus.cfg_base),
         .cfg_limit (bus.cfg_limit),
         .cfg_perm  (bus.cfg_perm),
         .addr      (bus.addr),
         .hit       (hit[g]),
         .rd_ok     (rd_ok[g]),
         .wr_ok     (wr_ok[g])
      );
   end

   // Descending scan so the lowest matching index is the one left standing.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      win_rd    = 1'b0;
      win_wr    = 1'b0;
      for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
         if (hit[i]) begin
            win_found = 1'b1;
            win_idx   = IDX_W'(i);
            win_rd    = rd_ok[i];
            win_wr    = wr_ok[i];
         end
      end
   end

   always_comb begin
      dec_rd   = 1'b0;
      dec_wr   = 1'b0;
      dec_viol = 1'b0;
      dec_hit  = hit_p1;
      if (bus.memread && bus.memwrite) begin
         dec_viol = 1'b1;
         dec_hit  = '0;
      end else if (bus.memread || bus.memwrite) begin
         if (!win_found) begin
            dec_viol = 1'b1;
         end else begin
            dec_hit = win_idx;
            if (bus.memread) begin
               dec_rd   = win_rd;
               dec_viol = !win_rd;
            end else begin
               dec_wr   = win_wr;
               dec_viol = !win_wr;
            end
         end
      end
   end

   // Clear is applied first so a same-cycle violation is captured afresh.
   always_comb begin
      state_d     = bus.viol_clr ? CLEAR : state_p1;
      viol_addr_d = viol_addr_p1;
      viol_cnt_d  = bus.viol_clr ? '0 : viol_cnt_p1;
      if (dec_viol) begin
         if (state_d == CLEAR) begin
            state_d     = CAPTURED;
            viol_addr_d = bus.addr;
         end
         viol_cnt_d = sat_inc(viol_cnt_d);
      end
   end

   // Decision stage boundary: everything below is visible one cycle later.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_p1        <= 1'b0;
         wr_p1        <= 1'b0;
         viol_p1      <= 1'b0;
         hit_p1       <= '0;
         state_p1     <= CLEAR;
         viol_addr_p1 <= '0;
         viol_cnt_p1  <= '0;
      end else begin
         rd_p1        <= dec_rd;
         wr_p1        <= dec_wr;
         viol_p1      <= dec_viol;
         hit_p1       <= dec_hit;
         state_p1     <= state_d;
         viol_addr_p1 <= viol_addr_d;
         viol_cnt_p1  <= viol_cnt_d;
      end
   end

   assign bus.rd          = rd_p1;
   assign bus.w           = wr_p1;
   assign bus.viol        = viol_p1;
   assign bus.hit_idx     = hit_p1;
   assign bus.viol_sticky = (state_p1 == CAPTURED);
   assign bus.viol_addr   = viol_addr_p1;
   assign bus.viol_cnt    = viol_cnt_p1;

endmodule

// File: tb/tb_mem_guard.sv
// Self-checking bench for mem_guard: directed scenarios plus randomized
// traffic against a region-table reference model; honours MEM_GUARD_LOCK_EN.
module tb_mem_guard;

   localparam int NR      = 4;
   localparam int AW      = 32;
   localparam int CW      = 2;
   localparam int IW      = 2;
   localparam int CNT_MAX = (1 << CW) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int errors = 0;
   int checks = 0;

   mem_guard_if #(.ADDR_W(AW), .IDX_W(IW), .CNT_W(CW)) bus ();

   mem_guard #(.NUM_REGIONS(NR), .ADDR_W(AW), .CNT_W(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Reference model state: the region table and the expected outputs.
   logic [31:0] m_base  [NR];
   logic [31:0] m_limit [NR];
   logic [2:0]  m_perm  [NR];
   bit          m_lock;
   bit          exp_rd, exp_w, exp_viol, exp_sticky;
   logic [31:0] exp_vaddr;
   int          exp_cnt, exp_hit;

   task automatic model_reset();
      for (int i = 0; i < NR; i++) begin
         m_base[i]  = 0;
         m_limit[i] = (i == 0) ? 32'd4 : 32'd0;
         m_perm[i]  = (i == 0) ? 3'b111 : 3'b000;
      end
      m_lock = 0;
      exp_rd = 0; exp_w = 0; exp_viol = 0; exp_sticky = 0;
      exp_vaddr = 0; exp_cnt = 0; exp_hit = 0;
   endtask

   task automatic model_step(input logic [31:0] a, input bit mr, input bit mw,
                             input bit we, input int idx, input logic [31:0] b,
                             input logic [31:0] l, input logic [2:0] p, input bit clr);
      int win;
      win = -1;
      for (int i = 0; i < NR; i++)
         if (win < 0 && m_perm[i][2] && m_base[i] <= a && a <= m_limit[i]) win = i;
      exp_rd = 0; exp_w = 0; exp_viol = 0;
      if (mr && mw) begin
         exp_viol = 1; exp_hit = 0;
      end else if (mr || mw) begin
         if (win < 0) exp_viol = 1;
         else begin
            exp_hit = win;
            if (mr) begin exp_rd = m_perm[win][0]; exp_viol = !m_perm[win][0]; end
            else    begin exp_w  = m_perm[win][1]; exp_viol = !m_perm[win][1]; end
         end
      end
      if (clr) begin exp_sticky = 0; exp_cnt = 0; end
      if (exp_viol) begin
         if (!exp_sticky) begin exp_sticky = 1; exp_vaddr = a; end
         if (exp_cnt < CNT_MAX) exp_cnt++;
      end
      if (we && !m_lock) begin
         m_base[idx] = b; m_limit[idx] = l; m_perm[idx] = p;
`ifdef MEM_GUARD_LOCK_EN
         if (idx == NR - 1 && p[2]) m_lock = 1;
`endif
      end
   endtask

   task automatic drive_idle();
      bus.memread = 0; bus.memwrite = 0; bus.addr = 0; bus.cfg_we = 0;
      bus.cfg_idx = 0; bus.cfg_base = 0; bus.cfg_limit = 0; bus.cfg_perm = 0;
      bus.viol_clr = 0;
   endtask

   // One clock with the given inputs; outputs are settled when this returns.
   task automatic step(input logic [31:0] a, input bit mr, input bit mw,
                       input bit we, input int idx, input logic [31:0] b,
                       input logic [31:0] l, input logic [2:0] p, input bit clr);
      bus.addr = a; bus.memread = mr; bus.memwrite = mw; bus.cfg_we = we;
      bus.cfg_idx = IW'(idx); bus.cfg_base = b; bus.cfg_limit = l;
      bus.cfg_perm = p; bus.viol_clr = clr;
      @(posedge clk);
      model_step(a, mr, mw, we, idx, b, l, p, clr);
      #1;
      drive_idle();
   endtask

   task automatic rd_at(input logic [31:0] a);  step(a, 1, 0, 0, 0, 0, 0, 0, 0); endtask
   task automatic wr_at(input logic [31:0] a);  step(a, 0, 1, 0, 0, 0, 0, 0, 0); endtask
   task automatic clear_capture();              step(0, 0, 0, 0, 0, 0, 0, 0, 1); endtask
   task automatic cfg(input int idx, input logic [31:0] b, input logic [31:0] l,
                      input logic [2:0] p);     step(0, 0, 0, 1, idx, b, l, p, 0); endtask

   task automatic apply_reset();
      drive_idle();
      rst = 1;
      repeat (2) @(posedge clk);
      model_reset();
      #1;
      rst = 0;
   endtask

   task automatic test_reset();
      apply_reset();
      checks++; if (bus.rd !== 1'b0) begin errors++; $display("FAIL reset_rd got=%0b want=0", bus.rd); end
      checks++; if (bus.w !== 1'b0) begin errors++; $display("FAIL reset_w got=%0b want=0", bus.w); end
      checks++; if (bus.viol !== 1'b0) begin errors++; $display("FAIL reset_viol got=%0b want=0", bus.viol); end
      checks++; if (bus.viol_sticky !== 1'b0) begin errors++; $display("FAIL reset_sticky got=%0b want=0", bus.viol_sticky); end
      checks++; if (bus.viol_addr !== 32'd0) begin errors++; $display("FAIL reset_vaddr got=%0h want=0", bus.viol_addr); end
      checks++; if (bus.viol_cnt !== 2'd0) begin errors++; $display("FAIL reset_cnt got=%0d want=0", bus.viol_cnt); end
      checks++; if (bus.hit_idx !== 2'd0) begin errors++; $display("FAIL reset_hit got=%0d want=0", bus.hit_idx); end
`ifdef MEM_GUARD_LOCK_EN
      checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL reset_locked got=%0b want=0", bus.locked); end
`endif
   endtask

   task automatic test_legacy();
      rd_at(2);
      checks++; if (bus.rd !== 1'b1 || bus.viol !== 1'b0 || bus.hit_idx !== 2'd0) begin
         errors++; $display("FAIL legacy_read rd=%0b viol=%0b hit=%0d want 1/0/0", bus.rd, bus.viol, bus.hit_idx); end
      rd_at(5);
      checks++; if (bus.viol !== 1'b1 || bus.rd !== 1'b0) begin
         errors++; $display("FAIL legacy_out viol=%0b rd=%0b want 1/0", bus.viol, bus.rd); end
      checks++; if (bus.viol_sticky !== 1'b1 || bus.viol_addr !== 32'd5 || bus.viol_cnt !== 2'd1) begin
         errors++; $display("FAIL legacy_capture sticky=%0b addr=%0h cnt=%0d want 1/5/1", bus.viol_sticky, bus.viol_addr, bus.viol_cnt); end
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      checks++; if (bus.viol !== 1'b0 || bus.viol_sticky !== 1'b1) begin
         errors++; $display("FAIL viol_pulse viol=%0b sticky=%0b want 0/1", bus.viol, bus.viol_sticky); end
      clear_capture();
      checks++; if (bus.viol_sticky !== 1'b0 || bus.viol_cnt !== 2'd0) begin
         errors++; $display("FAIL clear sticky=%0b cnt=%0d want 0/0", bus.viol_sticky, bus.viol_cnt); end
   endtask

   task automatic test_region_perm();
      cfg(1, 32'h100, 32'h1FF, 3'b101);
      rd_at(32'h180);
      checks++; if (bus.rd !== 1'b1 || bus.hit_idx !== 2'd1 || bus.viol !== 1'b0) begin
         errors++; $display("FAIL region_read rd=%0b hit=%0d viol=%0b want 1/1/0", bus.rd, bus.hit_idx, bus.viol); end
      wr_at(32'h180);
      checks++; if (bus.viol !== 1'b1 || bus.w !== 1'b0) begin
         errors++; $display("FAIL region_write viol=%0b w=%0b want 1/0", bus.viol, bus.w); end
      step(32'h200, 1, 0, 0, 0, 0, 0, 0, 1);
      checks++; if (bus.viol !== 1'b1 || bus.viol_addr !== 32'h200 || bus.viol_cnt !== 2'd1) begin
         errors++; $display("FAIL nomatch viol=%0b addr=%0h cnt=%0d want 1/200/1", bus.viol, bus.viol_addr, bus.viol_cnt); end
   endtask

   task automatic test_overlap();
      cfg(0, 0, 32'h10, 3'b101);
      cfg(1, 0, 32'h10, 3'b111);
      wr_at(8);
      checks++; if (bus.viol !== 1'b1 || bus.w !== 1'b0 || bus.hit_idx !== 2'd0) begin
         errors++; $display("FAIL overlap_write viol=%0b w=%0b hit=%0d want 1/0/0", bus.viol, bus.w, bus.hit_idx); end
      cfg(2, 32'h20, 32'h1F, 3'b111);
      rd_at(32'h20);
      checks++; if (bus.viol !== 1'b1 || bus.rd !== 1'b0) begin
         errors++; $display("FAIL inverted_range viol=%0b rd=%0b want 1/0", bus.viol, bus.rd); end
   endtask

   task automatic test_illegal_saturation();
      clear_capture();
      step(0, 1, 1, 0, 0, 0, 0, 0, 0);
      checks++; if (bus.rd !== 1'b0 || bus.w !== 1'b0 || bus.viol !== 1'b1 || bus.hit_idx !== 2'd0) begin
         errors++; $display("FAIL illegal rd=%0b w=%0b viol=%0b hit=%0d want 0/0/1/0", bus.rd, bus.w, bus.viol, bus.hit_idx); end
      for (int i = 0; i < 4; i++) rd_at(32'h500 + i);
      checks++; if (bus.viol_cnt !== 2'd3 || bus.viol_addr !== 32'd0) begin
         errors++; $display("FAIL saturate cnt=%0d addr=%0h want 3/0", bus.viol_cnt, bus.viol_addr); end
      step(9, 0, 1, 0, 0, 0, 0, 0, 1);
      checks++; if (bus.viol_cnt !== 2'd1 || bus.viol_addr !== 32'd9 || bus.viol_sticky !== 1'b1) begin
         errors++; $display("FAIL clr_and_viol cnt=%0d addr=%0h sticky=%0b want 1/9/1", bus.viol_cnt, bus.viol_addr, bus.viol_sticky); end
   endtask

   task automatic test_cfg_timing();
      cfg(1, 0, 0, 3'b000);
      cfg(0, 0, 4, 3'b111);
      step(1, 1, 0, 1, 0, 0, 4, 3'b011, 0);
      checks++; if (bus.rd !== 1'b1 || bus.viol !== 1'b0) begin
         errors++; $display("FAIL cfg_old_used rd=%0b viol=%0b want 1/0", bus.rd, bus.viol); end
      rd_at(1);
      checks++; if (bus.viol !== 1'b1 || bus.rd !== 1'b0) begin
         errors++; $display("FAIL cfg_new_used viol=%0b rd=%0b want 1/0", bus.viol, bus.rd); end
   endtask

   task automatic test_rst_midop();
      bus.addr = 5; bus.memread = 1;
      rst = 1;
      @(posedge clk);
      model_reset();
      #1;
      rst = 0;
      drive_idle();
      checks++; if (bus.viol !== 1'b0 || bus.rd !== 1'b0 || bus.viol_sticky !== 1'b0 || bus.viol_cnt !== 2'd0) begin
         errors++; $display("FAIL rst_midop viol=%0b rd=%0b sticky=%0b cnt=%0d want 0/0/0/0", bus.viol, bus.rd, bus.viol_sticky, bus.viol_cnt); end
      rd_at(2);
      checks++; if (bus.rd !== 1'b1 || bus.viol !== 1'b0) begin
         errors++; $display("FAIL rst_legacy rd=%0b viol=%0b want 1/0", bus.rd, bus.viol); end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         int op;
         logic [31:0] a;
         bit mr, mw, we, clr;
         op  = $urandom_range(0, 9);
         a   = $urandom_range(0, 70);
         mr  = (op <= 3) || (op == 7);
         mw  = (op >= 4 && op <= 7);
         we  = (op == 9) || ($urandom_range(0, 5) == 0);
         clr = ($urandom_range(0, 9) == 0);
         step(a, mr, mw, we, $urandom_range(0, NR - 1), $urandom_range(0, 63),
              $urandom_range(0, 63), 3'($urandom_range(0, 7)), clr);
         checks++;
         if (bus.rd !== exp_rd || bus.w !== exp_w || bus.viol !== exp_viol ||
             bus.hit_idx !== IW'(exp_hit)) begin
            errors++;
            $display("FAIL rand_decision n=%0d rd/w/viol/hit got=%0b/%0b/%0b/%0d want=%0b/%0b/%0b/%0d",
                     n, bus.rd, bus.w, bus.viol, bus.hit_idx, exp_rd, exp_w, exp_viol, exp_hit);
         end
         checks++;
         if (bus.viol_sticky !== exp_sticky || bus.viol_cnt !== CW'(exp_cnt) ||
             (exp_sticky && bus.viol_addr !== exp_vaddr)) begin
            errors++;
            $display("FAIL rand_capture n=%0d sticky/cnt/addr got=%0b/%0d/%0h want=%0b/%0d/%0h",
                     n, bus.viol_sticky, bus.viol_cnt, bus.viol_addr, exp_sticky, exp_cnt, exp_vaddr);
         end
`ifdef MEM_GUARD_LOCK_EN
         checks++;
         if (bus.locked !== m_lock) begin
            errors++; $display("FAIL rand_locked n=%0d got=%0b want=%0b", n, bus.locked, m_lock);
         end
`endif
      end
   endtask

`ifdef MEM_GUARD_LOCK_EN
   task automatic test_lock();
      apply_reset();
      cfg(NR - 1, 32'h40, 32'h4F, 3'b100);
      checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL lock_set got=%0b want=1", bus.locked); end
      cfg(0, 0, 0, 3'b000);
      rd_at(2);
      checks++; if (bus.rd !== 1'b1 || bus.viol !== 1'b0) begin
         errors++; $display("FAIL lock_drop rd=%0b viol=%0b want 1/0", bus.rd, bus.viol); end
      apply_reset();
      checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL lock_rst got=%0b want=0", bus.locked); end
      wr_at(4);
      checks++; if (bus.w !== 1'b1 || bus.viol !== 1'b0) begin
         errors++; $display("FAIL lock_rst_window w=%0b viol=%0b want 1/0", bus.w, bus.viol); end
   endtask
`endif

   initial begin
      drive_idle();
      model_reset();
      test_reset();
      test_legacy();
      test_region_perm();
      test_overlap();
      test_illegal_saturation();
      test_cfg_timing();
      test_rst_midop();
      test_random();
`ifdef MEM_GUARD_LOCK_EN
      test_lock();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
